// File: rtl/mult8x8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult8x8_seq_ctrl
//
// Sequencer that forms an unsigned 8x8 -> 16-bit product by time-sharing one
// external 4x4 multiplier over four nibble steps. Each partial product is
// shifted into place and summed into a 16-bit accumulator.
//
// Parameters:
//   MUL_LAT    latency of the attached 4x4 multiplier in clocks.
//              0 = combinational, 1 = registered. No other values are supported.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b is valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   a, b       8-bit unsigned operands, sampled on the accepting edge
//   out_valid  result is valid (high only in DONE)
//   out_ready  consumer accepts the result
//   result     16-bit product, held after hand-off until the next result
//   busy       high whenever the sequencer is not IDLE
//   mul_a      nibble operand A to the shared 4x4 multiplier
//   mul_b      nibble operand B to the shared 4x4 multiplier
//   mul_p      8-bit product returned by the shared 4x4 multiplier
// -----------------------------------------------------------------------------
module mult8x8_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    // Last step index: the final partial product arrives MUL_LAT steps after
    // the last operand issue at step 3.
    localparam logic [2:0] LAST_K = 3'(3 + MUL_LAT);
    localparam logic [2:0] LAT_K  = 3'(MUL_LAT);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc;
    logic [2:0]  k;
    logic [1:0]  slice;
    logic        acc_en;
    logic [15:0] sum;

    // Place a partial product according to the nibble slice it came from:
    // slice 0 is lo*lo, slices 1 and 2 are the cross terms, slice 3 is hi*hi.
    function automatic logic [15:0] align(input logic [7:0] p, input logic [1:0] s);
        logic [15:0] r;
        case (s)
            2'd0:    r = {8'd0, p};
            2'd3:    r = {p, 8'd0};
            default: r = {4'd0, p, 4'd0};
        endcase
        return r;
    endfunction

    // The product on mul_p belongs to the operands issued MUL_LAT steps ago.
    assign slice  = 2'(k - LAT_K);
    assign acc_en = (state == MUL) && ((MUL_LAT == 0) || (k != 3'd0));
    assign sum    = acc + align(mul_p, slice);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        mul_a     = 4'd0;
        mul_b     = 4'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nx = MUL;
                end
            end
            MUL: begin
                // Issue order: lo*lo, hi*lo, lo*hi, hi*hi (k[0] picks the
                // a nibble, k[1] picks the b nibble).
                if (k < 3'd4) begin
                    mul_a = k[0] ? a_r[7:4] : a_r[3:0];
                    mul_b = k[1] ? b_r[7:4] : b_r[3:0];
                end
                if (k == LAST_K) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= 8'd0;
            b_r    <= 8'd0;
            acc    <= 16'd0;
            k      <= 3'd0;
            result <= 16'd0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_r <= a;
                b_r <= b;
                acc <= 16'd0;
                k   <= 3'd0;
            end else if (state == MUL) begin
                if (acc_en) begin
                    acc <= sum;
                end
                // The step counter parks at LAST_K; it is re-armed on accept.
                if (k == LAST_K) begin
                    result <= sum;
                end else begin
                    k <= k + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult8x8_seq_ctrl
//
// Bench for mult8x8_seq_ctrl. Two instances run side by side: one with a
// combinational 4x4 multiplier (MUL_LAT=0) and one with a registered one
// (MUL_LAT=1). A transaction-level model predicts the handshake outputs,
// issued nibble pairs and the product for every cycle; directed tests pin the
// model with hand-computed literals, then a randomized sweep with out_ready
// stalls runs on both instances concurrently.
// -----------------------------------------------------------------------------
module tb_mult8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  a         [2];
    logic [7:0]  b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] result    [2];
    logic        busy      [2];
    logic [3:0]  mul_a     [2];
    logic [3:0]  mul_b     [2];
    logic [7:0]  mp0;
    logic [7:0]  mp1 = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared 4x4 multipliers: combinational for instance 0, registered for 1.
    assign mp0 = 8'(mul_a[0]) * 8'(mul_b[0]);
    always @(posedge clk) mp1 <= 8'(mul_a[1]) * 8'(mul_b[1]);

    mult8x8_seq_ctrl #(.MUL_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .busy(busy[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mp0)
    );

    mult8x8_seq_ctrl #(.MUL_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .busy(busy[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mp1)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", nm, idx, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase 0 = idle, 1 = computing, 2 = result offered.
    // cnt is the number of clocks spent computing since the accepting edge.
    // ------------------------------------------------------------------
    int          ph    [2] = '{0, 0};
    int          cnt   [2] = '{0, 0};
    int          ndone [2] = '{0, 0};
    int          lat   [2] = '{0, 1};
    logic [15:0] expv  [2] = '{16'd0, 16'd0};
    logic [15:0] resm  [2] = '{16'd0, 16'd0};
    logic [7:0]  am    [2] = '{8'd0, 8'd0};
    logic [7:0]  bm    [2] = '{8'd0, 8'd0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            if (!rst_n) begin
                ph[i]   = 0;
                cnt[i]  = 0;
                resm[i] = 16'd0;
            end
            ea = 4'd0;
            eb = 4'd0;
            if (ph[i] == 1 && cnt[i] < 4) begin
                ea = (cnt[i] % 2 == 0) ? am[i][3:0] : am[i][7:4];
                eb = (cnt[i] < 2)      ? bm[i][3:0] : bm[i][7:4];
            end
            chk("in_ready",  i, 32'(in_ready[i]),  32'(ph[i] == 0));
            chk("out_valid", i, 32'(out_valid[i]), 32'(ph[i] == 2));
            chk("busy",      i, 32'(busy[i]),      32'(ph[i] != 0));
            chk("excl",      i, 32'(in_ready[i] & out_valid[i]), 32'd0);
            chk("result",    i, 32'(result[i]),    32'(resm[i]));
            chk("mul_pair",  i, {24'd0, mul_a[i], mul_b[i]}, {24'd0, ea, eb});
            if (rst_n) begin
                case (ph[i])
                    0: if (in_valid[i]) begin
                        ph[i]   = 1;
                        cnt[i]  = 0;
                        am[i]   = a[i];
                        bm[i]   = b[i];
                        expv[i] = 16'(a[i]) * 16'(b[i]);
                    end
                    1: if (cnt[i] == 3 + lat[i]) begin
                        ph[i]   = 2;
                        resm[i] = expv[i];
                    end else begin
                        cnt[i]++;
                    end
                    default: if (out_ready[i]) begin
                        ph[i] = 0;
                        ndone[i]++;
                    end
                endcase
            end
        end
    end

    // Present an operand pair and hold it until accepted; called and returns
    // one time step after a rising edge. Operands are scrambled afterwards so
    // a design that keeps reading a/b would be caught.
    task automatic send(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        output bit ok);
        a[idx] = av;
        b[idx] = bv;
        in_valid[idx] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", idx, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        a[idx] = 8'($urandom);
        b[idx] = 8'($urandom);
    endtask

    // Count falling edges from the accepting edge until out_valid is seen.
    task automatic wait_out(input int idx, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            n++;
            if (out_valid[idx]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("out_timeout", idx, 32'(seen), 32'd1);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    bit sweep_done [2] = '{1'b0, 1'b0};
    int accepted   [2] = '{0, 0};

    task automatic sweep(input int idx);
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) realign();
            send(idx, 8'($urandom), 8'($urandom), ok);
            if (ok) accepted[idx]++;
        end
        sweep_done[idx] = 1'b1;
    endtask

    task automatic stall(input int idx);
        while (!sweep_done[idx]) begin
            @(posedge clk);
            #1;
            out_ready[idx] = ($urandom_range(0, 3) != 0);
        end
        out_ready[idx] = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n;
        logic [7:0]  pair [4];
        int          exp_pair [4] = '{'h24, 'h14, 'h23, 'h13};
        int          base [2];

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            a[i]         = 8'd0;
            b[i]         = 8'd0;
            out_ready[i] = 1'b1;
        end

        // Reset values
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready",  i, 32'(in_ready[i]),  32'd1);
            chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
            chk("rst_busy",      i, 32'(busy[i]),      32'd0);
            chk("rst_result",    i, 32'(result[i]),    32'd0);
            chk("rst_mul",       i, {24'd0, mul_a[i], mul_b[i]}, 32'd0);
        end
        realign();
        rst_n = 1'b1;
        realign();

        // Max operands, latency 5 with a combinational multiplier
        send(0, 8'hFF, 8'hFF, ok);
        wait_out(0, n);
        chk("t1_latency", 0, 32'(n), 32'd5);
        chk("t1_result",  0, 32'(result[0]), 32'h0000FE01);
        @(negedge clk);
        chk("t1_idle", 0, 32'(in_ready[0]), 32'd1);
        realign();

        // Issue order of nibble pairs
        send(0, 8'h12, 8'h34, ok);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            pair[j] = {mul_a[0], mul_b[0]};
        end
        for (int j = 0; j < 4; j++) chk("t2_pair", j, 32'(pair[j]), 32'(exp_pair[j]));
        wait_out(0, n);
        chk("t2_result", 0, 32'(result[0]), 32'h000003A8);
        realign();

        // Registered multiplier: one extra clock of latency
        send(1, 8'hA5, 8'h3C, ok);
        wait_out(1, n);
        chk("t3_latency", 1, 32'(n), 32'd6);
        chk("t3_result",  1, 32'(result[1]), 32'h000026AC);
        realign();

        // Zero operand still runs the full sequence
        send(0, 8'h00, 8'h9B, ok);
        wait_out(0, n);
        chk("t_zero_latency", 0, 32'(n), 32'd5);
        chk("t_zero_result",  0, 32'(result[0]), 32'd0);
        realign();

        // Backpressure: DONE held, new operands refused until hand-off
        out_ready[0] = 1'b0;
        send(0, 8'h07, 8'h09, ok);
        wait_out(0, n);
        realign();
        in_valid[0] = 1'b1;
        a[0] = 8'h01;
        b[0] = 8'hC3;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("t4_hold_result", j, 32'(result[0]),    32'h0000003F);
            chk("t4_hold_ready",  j, 32'(in_ready[0]),  32'd0);
            chk("t4_hold_valid",  j, 32'(out_valid[0]), 32'd1);
        end
        realign();
        out_ready[0] = 1'b1;
        send(0, 8'h01, 8'hC3, ok);
        wait_out(0, n);
        chk("t4_latency", 0, 32'(n), 32'd5);
        chk("t4_result",  0, 32'(result[0]), 32'h000000C3);
        realign();

        // Reset at step 2 discards the operation
        send(0, 8'h5A, 8'h77, ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("t5_in_ready",  0, 32'(in_ready[0]),  32'd1);
        chk("t5_mul",       0, {24'd0, mul_a[0], mul_b[0]}, 32'd0);
        chk("t5_result",    0, 32'(result[0]), 32'd0);
        realign();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("t5_no_result", j, 32'(out_valid[0]), 32'd0);
        end
        realign();

        // Randomized sweep on both instances with consumer stalls
        base[0] = ndone[0];
        base[1] = ndone[1];
        fork
            sweep(0);
            sweep(1);
            stall(0);
            stall(1);
        join
        repeat (20) realign();
        for (int i = 0; i < 2; i++) begin
            chk("sweep_accepted",  i, 32'(accepted[i]), 32'd1000);
            chk("sweep_completed", i, 32'(ndone[i] - base[i]), 32'(accepted[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
